dino_game_sequencer: RTL and testbench
======================================

Name: dino_game_sequencer

Overview:
- Top-level run controller for the dino game.
- Sequences the game through idle, start, run, pause and game-over, and generates the `game_tick` strobe that paces obstacle movement.
- Speeds `game_tick` up as the score rises, keeps score and high score, and issues a one-cycle clear to the object/obstacle logic at each new game.
- Sits between the keyboard decoder and collision detector (inputs) and the object controller, score display and VGA renderer (outputs).

Parameters:
- CNT_W, 24, width of tick period counter.
- TICK_BASE, 400000, `game_tick` period in clk cycles at level 0.
- TICK_STEP, 20000, period reduction per speed level.
- TICK_MIN, 100000, floor on tick period.
- TICKS_PER_POINT, 8, `game_tick`s per score increment.
- SCORE_PER_LEVEL, 100, score points per speed level.
- MAX_LEVEL, 15, speed level saturation value.
- HOLDOFF, 50000000, clk cycles after game over during which keys are ignored.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset; all state clears while rst==0.
- key_valid  in  1  one-cycle pulse: new key press decoded.
- key_num  in  4  key code (0 ENTER, 1 SPACE, 2 UP, 3 DOWN); valid with key_valid.
- collision  in  1  level: dino overlaps an enabled obstacle.
- game_state  out  3  0 IDLE, 1 START, 2 RUN, 3 PAUSE, 4 OVER.
- game_tick  out  1  one-cycle movement strobe; only in RUN.
- obj_clear  out  1  one-cycle pulse: clear all obstacles, park dino on ground.
- score  out  16  current score, binary, saturates at 16'hFFFF.
- high_score  out  16  best score since reset.
- speed_level  out  4  current level, 0..MAX_LEVEL.

Behaviour:
- Reset (rst==0, async):
  - game_state=IDLE; game_tick=0; obj_clear=0.
  - score=0; high_score=0; speed_level=0.
  - Tick counter, point counter and holdoff counter all 0.
- Outputs are registered.
- A "start key" is key_valid with key_num in {0,1,2}. DOWN never starts or resumes a game.
- IDLE:
  - A start key moves to START on the next edge.
  - All other input is ignored.
- START (exactly 1 cycle):
  - obj_clear=1.
  - score, speed_level, tick counter and point counter are cleared.
  - Next state RUN.
  - Keys and collision are ignored in this cycle.
- RUN:
  - Tick counter increments each cycle.
  - When counter >= period-1, it wraps to 0 and game_tick=1 for that one cycle.
  - period = max(TICK_BASE - speed_level*TICK_STEP, TICK_MIN), computed CNT_W bits wide with no underflow (clamps to TICK_MIN).
  - Each game_tick increments the point counter. On reaching TICKS_PER_POINT it resets and score increments by 1.
  - When the new score is a nonzero multiple of SCORE_PER_LEVEL, speed_level increments, saturating at MAX_LEVEL.
  - A new period takes effect from the next counter comparison. The >= comparison guarantees a wrap even if the period shrank below the current count.
  - collision==1: next state OVER. game_tick is forced to 0 in that cycle and score does not change.
  - key_valid with ENTER (and no collision): next state PAUSE.
  - Priority: collision > ENTER > tick processing.
- PAUSE:
  - Tick counter, point counter and score are frozen; game_tick=0; collision is ignored.
  - key_valid with ENTER: return to RUN and resume counting from the frozen count.
- OVER:
  - On entry cycle, high_score is loaded with score if score > high_score.
  - Holdoff counter counts 0..HOLDOFF-1; start keys are ignored while counting.
  - After holdoff, a start key moves to START. This does not pass through IDLE.
  - score remains visible until START.
- Simultaneous events:
  - A key and collision in the same RUN cycle resolve as collision.
  - A tick wrap and collision in the same cycle produce no tick and no score change.
- Reset asserted mid-game aborts immediately to the reset values, including high_score.
- Illegal game_state encodings (5-7) go to IDLE on the next edge.

Test Plan (bench overrides: TICK_BASE=10, TICK_STEP=2, TICK_MIN=4, TICKS_PER_POINT=2, SCORE_PER_LEVEL=3, MAX_LEVEL=15, HOLDOFF=5):
1. Reset then SPACE pulse:
   - game_state goes 0→1→2 on consecutive edges.
   - obj_clear high for exactly the START cycle.
   - The first game_tick comes 10 cycles after entering RUN, then every 10 cycles.
2. Run 6 ticks:
   - score=3 and speed_level=1.
   - The following tick spacing is 8 cycles.
   - At speed_level≥3, spacing stays 4, never below.
3. Collision asserted on the same cycle the counter wraps:
   - No game_tick; score unchanged; next state 4.
   - high_score equals that score.
4. In OVER:
   - UP pulse at cycle 2 of holdoff is ignored.
   - UP pulse after cycle 5 gives START (obj_clear pulse) then RUN with score=0 and high_score retained.
5. ENTER in RUN:
   - PAUSE; no game_tick for 50 cycles; collision ignored.
   - Second ENTER resumes, and the next tick arrives after the remaining count.
   - DOWN does not resume.
6. rst driven low mid-RUN, asynchronously between edges:
   - All outputs 0 immediately (game_state=0, high_score=0).
   - State remains IDLE after release until a start key.

Source files
------------

// File: rtl/dino_game_sequencer_if.sv
// Signal bundle between the dino game run controller and its neighbours:
// key decoder and collision detector in, object/score/VGA logic out.
interface dino_game_sequencer_if;
  logic        key_valid;
  logic [3:0]  key_num;
  logic        collision;
  logic [2:0]  game_state;
  logic        game_tick;
  logic        obj_clear;
  logic [15:0] score;
  logic [15:0] high_score;
  logic [3:0]  speed_level;

  modport master (
    input  key_valid,
    input  key_num,
    input  collision,
    output game_state,
    output game_tick,
    output obj_clear,
    output score,
    output high_score,
    output speed_level
  );

  modport slave (
    output key_valid,
    output key_num,
    output collision,
    input  game_state,
    input  game_tick,
    input  obj_clear,
    input  score,
    input  high_score,
    input  speed_level
  );
endinterface

// File: rtl/dino_game_sequencer.sv
// Dino game run controller: game state machine, speed-scaled game_tick
// generator, score / high score / speed level keeping and new-game clear.
module dino_game_sequencer #(
  parameter int CNT_W           = 24,
  parameter int TICK_BASE       = 400000,
  parameter int TICK_STEP       = 20000,
  parameter int TICK_MIN        = 100000,
  parameter int TICKS_PER_POINT = 8,
  parameter int SCORE_PER_LEVEL = 100,
  parameter int MAX_LEVEL       = 15,
  parameter int HOLDOFF         = 50000000
) (
  input  logic clk,
  input  logic rst,
  dino_game_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int PROD_W = CNT_W + 4;
  localparam int PT_W   = $clog2(TICKS_PER_POINT + 1);
  localparam int LP_W   = $clog2(SCORE_PER_LEVEL + 1);
  localparam int HOLD_W = $clog2(HOLDOFF + 1);

  localparam logic [PROD_W-1:0] BASE_EXT = PROD_W'(TICK_BASE);
  localparam logic [PROD_W-1:0] STEP_EXT = PROD_W'(TICK_STEP);
  localparam logic [PROD_W-1:0] MIN_EXT  = PROD_W'(TICK_MIN);
  localparam logic [PT_W-1:0]   PT_LAST  = PT_W'(TICKS_PER_POINT - 1);
  localparam logic [LP_W-1:0]   LP_LAST  = LP_W'(SCORE_PER_LEVEL - 1);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLDOFF);
  localparam logic [3:0]        LVL_MAX  = 4'(MAX_LEVEL);

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [PT_W-1:0]     r_pt, w_pt_next;
  logic [LP_W-1:0]     r_lvl_pts, w_lvl_pts_next;
  logic [HOLD_W-1:0]   r_hold, w_hold_next;
  logic [15:0]         r_score, w_score_next;
  logic [15:0]         r_high, w_high_next;
  logic [3:0]          r_level, w_level_next;
  logic                r_tick, w_tick_next;
  logic                r_clear, w_clear_next;

  logic                w_start_key;
  logic                w_enter_key;
  logic                w_hold_done;
  logic                w_wrap;
  logic [PROD_W-1:0]   w_dec;
  logic [PROD_W-1:0]   w_period;
  logic [PROD_W-1:0]   w_cnt_plus1;

  assign w_start_key = bus.key_valid && (bus.key_num <= 4'd2);
  assign w_enter_key = bus.key_valid && (bus.key_num == 4'd0);
  assign w_hold_done = (r_hold == HOLD_END);

  // Period is worked out in a wider field so the subtraction can never wrap
  // around; anything at or below the floor clamps to TICK_MIN.
  assign w_dec       = PROD_W'(r_level) * STEP_EXT;
  assign w_period    = ((w_dec >= BASE_EXT) || ((BASE_EXT - w_dec) < MIN_EXT))
                       ? MIN_EXT : (BASE_EXT - w_dec);
  assign w_cnt_plus1 = PROD_W'(r_cnt) + PROD_W'(1);
  assign w_wrap      = (w_cnt_plus1 >= w_period);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_key) w_state_next = ST_START;
      ST_START: w_state_next = ST_RUN;
      ST_RUN: begin
        if (bus.collision)     w_state_next = ST_OVER;
        else if (w_enter_key)  w_state_next = ST_PAUSE;
      end
      ST_PAUSE: if (w_enter_key) w_state_next = ST_RUN;
      ST_OVER:  if (w_hold_done && w_start_key) w_state_next = ST_START;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_next     = r_cnt;
    w_pt_next      = r_pt;
    w_lvl_pts_next = r_lvl_pts;
    w_hold_next    = r_hold;
    w_score_next   = r_score;
    w_high_next    = r_high;
    w_level_next   = r_level;
    w_tick_next    = 1'b0;
    w_clear_next   = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (bus.collision) begin
          w_hold_next = '0;
          if (r_score > r_high) w_high_next = r_score;
        end else if (!w_enter_key) begin
          if (w_wrap) begin
            w_cnt_next  = '0;
            w_tick_next = 1'b1;
            if (r_pt == PT_LAST) begin
              w_pt_next = '0;
              if (r_score != 16'hFFFF) begin
                w_score_next = r_score + 16'd1;
                // Level points track score mod SCORE_PER_LEVEL without a divider.
                if (r_lvl_pts == LP_LAST) begin
                  w_lvl_pts_next = '0;
                  if (r_level != LVL_MAX) w_level_next = r_level + 4'd1;
                end else begin
                  w_lvl_pts_next = r_lvl_pts + LP_W'(1);
                end
              end
            end else begin
              w_pt_next = r_pt + PT_W'(1);
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (!w_hold_done) w_hold_next = r_hold + HOLD_W'(1);
      end
      default: ;
    endcase

    // Clear lands on the edge into START so the fresh game is visible with obj_clear.
    if (w_state_next == ST_START) begin
      w_clear_next   = 1'b1;
      w_cnt_next     = '0;
      w_pt_next      = '0;
      w_lvl_pts_next = '0;
      w_score_next   = '0;
      w_level_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pt      <= '0;
      r_lvl_pts <= '0;
      r_hold    <= '0;
      r_score   <= '0;
      r_high    <= '0;
      r_level   <= '0;
      r_tick    <= 1'b0;
      r_clear   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pt      <= w_pt_next;
      r_lvl_pts <= w_lvl_pts_next;
      r_hold    <= w_hold_next;
      r_score   <= w_score_next;
      r_high    <= w_high_next;
      r_level   <= w_level_next;
      r_tick    <= w_tick_next;
      r_clear   <= w_clear_next;
    end
  end

  assign bus.game_state  = r_state;
  assign bus.game_tick   = r_tick;
  assign bus.obj_clear   = r_clear;
  assign bus.score       = r_score;
  assign bus.high_score  = r_high;
  assign bus.speed_level = r_level;

endmodule

// File: tb/tb_dino_game_sequencer.sv
// Directed bench for dino_game_sequencer with shortened timing parameters.
module tb_dino_game_sequencer;

  localparam int TB_BASE = 10;
  localparam int TB_STEP = 2;
  localparam int TB_MIN  = 4;
  localparam int TB_TPP  = 2;
  localparam int TB_SPL  = 3;
  localparam int TB_MAXL = 15;
  localparam int TB_HOLD = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dino_game_sequencer_if bus ();

  dino_game_sequencer #(
    .CNT_W(24), .TICK_BASE(TB_BASE), .TICK_STEP(TB_STEP), .TICK_MIN(TB_MIN),
    .TICKS_PER_POINT(TB_TPP), .SCORE_PER_LEVEL(TB_SPL), .MAX_LEVEL(TB_MAXL),
    .HOLDOFF(TB_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        kv;
    logic [3:0]  kn;
    logic        col;
    logic [2:0]  st;
    logic        clr;
    logic        tick;
    logic [15:0] sc;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_num   = k;
    step();
    bus.key_valid = 1'b0;
    bus.key_num   = 4'd0;
  endtask

  // Steps until game_tick is seen or the budget runs out; n = edges taken.
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.game_tick && n < budget);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(bus.game_state), 0);
    chk({tag, "_tick"},  32'(bus.game_tick), 0);
    chk({tag, "_clear"}, 32'(bus.obj_clear), 0);
    chk({tag, "_score"}, 32'(bus.score), 0);
    chk({tag, "_high"},  32'(bus.high_score), 0);
    chk({tag, "_level"}, 32'(bus.speed_level), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, per, lvl, pt, sc, already, tick_seen;
    checks = 0;
    errors = 0;

    vecs[0] = '{1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 4'd3, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0};  // DOWN never starts
    vecs[2] = '{1'b0, 4'd0, 1'b1, 3'd0, 1'b0, 1'b0, 16'd0};  // collision ignored in IDLE
    vecs[3] = '{1'b1, 4'd5, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0};  // unknown key code
    vecs[4] = '{1'b1, 4'd1, 1'b0, 3'd1, 1'b1, 1'b0, 16'd0};  // SPACE -> START
    vecs[5] = '{1'b1, 4'd0, 1'b1, 3'd2, 1'b0, 1'b0, 16'd0};  // START ignores keys/collision
    vecs[6] = '{1'b0, 4'd0, 1'b0, 3'd2, 1'b0, 1'b0, 16'd0};

    rst = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_num   = 4'd0;
    bus.collision = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    // Test 1: table of single-cycle vectors
    for (int i = 0; i < 7; i++) begin
      bus.key_valid = vecs[i].kv;
      bus.key_num   = vecs[i].kn;
      bus.collision = vecs[i].col;
      step();
      $display("vec %0d: state=%0d clear=%0d tick=%0d score=%0d",
               i, bus.game_state, bus.obj_clear, bus.game_tick, bus.score);
      chk($sformatf("vec%0d_state", i), 32'(bus.game_state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_clear", i), 32'(bus.obj_clear), 32'(vecs[i].clr));
      chk($sformatf("vec%0d_tick", i),  32'(bus.game_tick), 32'(vecs[i].tick));
      chk($sformatf("vec%0d_score", i), 32'(bus.score), 32'(vecs[i].sc));
    end
    bus.key_valid = 1'b0;
    bus.collision = 1'b0;

    // Test 2: tick spacing and speed-up; one edge already spent in RUN
    lvl = 0; pt = 0; sc = 0; already = 1;
    for (int t = 1; t <= 26; t++) begin
      per = TB_BASE - TB_STEP * lvl;
      if (per < TB_MIN) per = TB_MIN;
      wait_tick(per - already + 5, n);
      chk($sformatf("tick%0d_spacing", t), 32'(n), 32'(per - already));
      already = 0;
      pt++;
      if (pt == TB_TPP) begin
        pt = 0;
        sc++;
        if ((sc % TB_SPL) == 0 && lvl < TB_MAXL) lvl++;
      end
      chk($sformatf("tick%0d_score", t), 32'(bus.score), 32'(sc));
      chk($sformatf("tick%0d_level", t), 32'(bus.speed_level), 32'(lvl));
      $display("tick %0d: spacing=%0d score=%0d level=%0d", t, n, bus.score, bus.speed_level);
    end

    // Test 3: collision on the wrap cycle (period is 4 here)
    repeat (3) step();
    chk("pre_wrap_notick", 32'(bus.game_tick), 0);
    bus.collision = 1'b1;
    step();
    bus.collision = 1'b0;
    $display("collide: state=%0d tick=%0d score=%0d high=%0d",
             bus.game_state, bus.game_tick, bus.score, bus.high_score);
    chk("collide_state", 32'(bus.game_state), 4);
    chk("collide_tick",  32'(bus.game_tick), 0);
    chk("collide_score", 32'(bus.score), 13);
    chk("collide_high",  32'(bus.high_score), 13);

    // Test 4: holdoff in OVER
    repeat (2) step();
    press(4'd2);
    $display("over: UP during holdoff -> state=%0d", bus.game_state);
    chk("holdoff_up_ignored", 32'(bus.game_state), 4);
    repeat (2) step();
    press(4'd3);
    $display("over: DOWN after holdoff -> state=%0d", bus.game_state);
    chk("over_down_ignored", 32'(bus.game_state), 4);
    press(4'd2);
    $display("over: UP after holdoff -> state=%0d clear=%0d", bus.game_state, bus.obj_clear);
    chk("restart_state", 32'(bus.game_state), 1);
    chk("restart_clear", 32'(bus.obj_clear), 1);
    chk("restart_score", 32'(bus.score), 0);
    step();
    chk("restart_run",       32'(bus.game_state), 2);
    chk("restart_clear_low", 32'(bus.obj_clear), 0);
    chk("restart_high",      32'(bus.high_score), 13);
    chk("restart_level",     32'(bus.speed_level), 0);

    // Test 5: pause at count 3, freeze, resume
    repeat (3) step();
    press(4'd0);
    $display("pause: state=%0d", bus.game_state);
    chk("pause_state", 32'(bus.game_state), 3);
    tick_seen = 0;
    for (int c = 0; c < 50; c++) begin
      bus.collision = (c % 7 == 3);
      step();
      if (bus.game_tick) tick_seen++;
    end
    bus.collision = 1'b0;
    chk("pause_no_ticks", 32'(tick_seen), 0);
    chk("pause_held",     32'(bus.game_state), 3);
    press(4'd3);
    chk("pause_down_ignored", 32'(bus.game_state), 3);
    press(4'd0);
    chk("resume_state", 32'(bus.game_state), 2);
    wait_tick(TB_BASE + 5, n);
    $display("resume: first tick after %0d cycles score=%0d", n, bus.score);
    chk("resume_spacing", 32'(n), 32'(TB_BASE - 3));
    chk("resume_score",   32'(bus.score), 0);

    // ENTER and collision together resolve as collision
    bus.key_valid = 1'b1;
    bus.key_num   = 4'd0;
    bus.collision = 1'b1;
    step();
    bus.key_valid = 1'b0;
    bus.collision = 1'b0;
    $display("enter+collision: state=%0d high=%0d", bus.game_state, bus.high_score);
    chk("enter_col_state", 32'(bus.game_state), 4);
    chk("enter_col_high",  32'(bus.high_score), 13);

    // Test 6: asynchronous reset mid-RUN
    repeat (6) step();
    press(4'd1);
    chk("game3_start", 32'(bus.game_state), 1);
    step();
    wait_tick(TB_BASE + 5, n);
    wait_tick(TB_BASE + 5, n);
    chk("game3_score", 32'(bus.score), 1);
    #3;
    rst = 1'b0;
    #1;
    $display("async reset: state=%0d score=%0d high=%0d", bus.game_state, bus.score, bus.high_score);
    chk_all_zero("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    chk("post_rst_idle", 32'(bus.game_state), 0);
    press(4'd1);
    $display("post reset SPACE: state=%0d", bus.game_state);
    chk("post_rst_start", 32'(bus.game_state), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
